// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: redirect selectors,
// default constants and the prefetch queue entry layout.
package fetch_pkg;

    localparam logic [1:0] PCSEL_IMD   = 2'b00;
    localparam logic [1:0] PCSEL_REGA  = 2'b01;
    localparam logic [1:0] PCSEL_INDEX = 2'b10;
    localparam logic [1:0] PCSEL_TRAP  = 2'b11;

    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned DEF_TRAP_PC = 64;
    localparam int unsigned DEF_PC_STEP = 4;

    typedef struct packed {
        logic [DEF_XLEN-1:0] instr;
        logic [DEF_XLEN-1:0] proximopc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with push/pop/flush; pointers wrap at DEPTH
// (a power of two), count is one bit wider than the pointers.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  entry_t                   wdata_i,
    output entry_t                   rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_pop;

    assign do_pop = pop_i & (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q + PW'(push_i);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: issues in-order GDM reads ahead of decode, buffers
// responses in a prefetch queue and flushes stale work on redirects.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [XLEN-1:0]  TRAP_PC  = XLEN'(DEF_TRAP_PC),
    parameter int               PC_STEP  = DEF_PC_STEP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fw_if_id_stall,
    input  logic             id_if_ready,
    output logic             if_id_valid,
    output logic [XLEN-1:0]  if_id_instrucao,
    output logic [XLEN-1:0]  if_id_proximopc,
    input  logic             id_if_selfontepc,
    input  logic [1:0]       id_if_seltipopc,
    input  logic [XLEN-1:0]  id_if_pcimd2ext,
    input  logic [XLEN-1:0]  id_if_rega,
    input  logic [XLEN-1:0]  id_if_pcindex,
    output logic             if_gdm_req,
    output logic [XLEN-1:0]  if_gdm_addr,
    input  logic             gdm_if_gnt,
    input  logic             gdm_if_rvalid,
    input  logic [XLEN-1:0]  gdm_if_data
);

    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] proximopc;
    } qentry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] target;
    logic            redirect, occ_ok, issue, push, pop;
    qentry_t         head, wentry;

    assign redirect = id_if_selfontepc;

    always_comb begin
        unique case (id_if_seltipopc)
            PCSEL_IMD:   target = id_if_pcimd2ext;
            PCSEL_REGA:  target = id_if_rega;
            PCSEL_INDEX: target = id_if_pcindex;
            PCSEL_TRAP:  target = TRAP_PC;
            default:     target = id_if_pcimd2ext;
        endcase
    end

    // Queue entries plus in-flight reads never exceed DEPTH, so pushes cannot overflow.
    assign occ_ok     = ({1'b0, count} + {1'b0, out_q}) < (CW+1)'(DEPTH);
    assign if_gdm_req = ~reset & ~redirect & occ_ok;
    assign if_gdm_addr = pc_q;
    assign issue      = if_gdm_req & gdm_if_gnt;
    assign push       = gdm_if_rvalid & ~redirect & (disc_q == '0);

    assign if_id_valid     = (count != '0) & ~fw_if_id_stall;
    assign pop             = if_id_valid & id_if_ready;
    assign if_id_instrucao = (count != '0) ? head.instr     : '0;
    assign if_id_proximopc = (count != '0) ? head.proximopc : '0;

    // Responses come back in order, so the address of the next kept one is a running counter.
    assign wentry = '{instr: gdm_if_data, proximopc: rsp_pc_q + STEP};

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        out_d    = out_q + CW'(issue) - CW'(gdm_if_rvalid);
        disc_d   = disc_q;
        if (redirect) begin
            pc_d     = target;
            rsp_pc_d = target;
            disc_d   = out_q - CW'(gdm_if_rvalid);
        end else begin
            if (issue) begin
                pc_d = pc_q + STEP;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + STEP;
            end
            if (gdm_if_rvalid && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (qentry_t)
    ) u_queue (
        .clk_i   (clock),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count)
    );

endmodule
